mdu: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers; the sequential companion to the

---
 rtl/mdu.sv | 129 ++++++++++++
 tb/tb_mdu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at accept, held in pending registers, and committed after a fixed latency.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi, pend_lo;
    logic               pend_wr;

    logic               is_mul, is_div;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;

    logic signed [63:0] smul;
    logic [63:0]        umul;
    logic [31:0]        b_safe, a_mag, b_mag, uq, ur, sq, sr;
    logic               a_neg, b_neg;

    assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign busy   = (state == BUSY);

    assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign umul = {32'd0, A} * {32'd0, B};

    // Division runs on magnitudes so that 0x80000000 / -1 wraps cleanly instead of
    // overflowing; a zero divisor is swapped for 1 and its result is never committed.
    assign b_safe = (B == 32'd0) ? 32'd1 : B;
    assign a_neg  = A[31];
    assign b_neg  = b_safe[31];
    assign a_mag  = a_neg ? (~A + 32'd1) : A;
    assign b_mag  = b_neg ? (~b_safe + 32'd1) : b_safe;
    assign uq     = a_mag / b_mag;
    assign ur     = a_mag % b_mag;
    assign sq     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    assign sr     = a_neg ? (~ur + 32'd1) : ur;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        case (MDUOp)
            OP_MULT:  begin {res_hi, res_lo} = smul; res_wr = 1'b1; end
            OP_MULTU: begin {res_hi, res_lo} = umul; res_wr = 1'b1; end
            OP_DIV:   begin res_lo = sq; res_hi = sr; res_wr = (B != 32'd0); end
            OP_DIVU:  begin res_lo = A / b_safe; res_hi = A % b_safe; res_wr = (B != 32'd0); end
            default:  ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && (is_mul || is_div)) next_state = BUSY;
            BUSY:    if (cnt == CNT_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            done    <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (is_mul || is_div) begin
                        cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_wr <= res_wr;
                    end else if (MDUOp == OP_MTHI) begin
                        HI <= A;
                    end else if (MDUOp == OP_MTLO) begin
                        LO <= A;
                    end
                end
            end else if (cnt == CNT_W'(1)) begin
                if (pend_wr) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected HI/LO and latency are queued at issue and
// compared when done pulses; HI/LO hold, ignored starts, MT writes and async reset are also checked.
module tb_mdu;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                           MTHI = 3'b100, MTLO = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  MDUOp = '0;
    logic [31:0] A = '0, B = '0;
    logic        busy, done;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_hi = '0, model_lo = '0;

    mdu #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; drives the op for one cycle and follows it to done.
    // inj > 0 pulses a MULT 3x3 start on that busy cycle, which must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                          input int inj);
        logic [31:0] hold_hi, hold_lo;
        exp_t e;
        int n;
        hold_hi = HI;
        hold_lo = LO;
        sb.push_back('{hi: ehi, lo: elo, lat: lat});
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            check("hold_hi", HI, hold_hi);
            check("hold_lo", LO, hold_lo);
            check("done_low", {31'd0, done}, 32'd0);
            if (n == inj) begin
                start = 1'b1; MDUOp = MULT; A = 32'd3; B = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_cycles", n, lat);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("hi", HI, e.hi);
            check("lo", LO, e.lo);
            check("latency", n, e.lat);
        end
        model_hi = HI === ehi ? ehi : ehi;
        model_lo = elo;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] p;
        int dcount;

        repeat (2) @(negedge clk);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_LAT, 0);
        // Issued on the done cycle: back-to-back accept.
        run_op(MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MULT_LAT, 0);
        run_op(DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, 0);
        run_op(DIVU,  32'd7, 32'd0, model_hi, model_lo, DIV_LAT, 0);
        run_op(DIV,   32'h1111_0000, 32'd0, model_hi, model_lo, DIV_LAT, 0);
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, 0);
        run_op(DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT, 0);
        run_op(DIVU,  32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 4);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 3)
                0: begin
                    p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
                    run_op(MULT, ra, rb, p[63:32], p[31:0], MULT_LAT, 0);
                end
                1: begin
                    p = {32'd0, ra} * {32'd0, rb};
                    run_op(MULTU, ra, rb, p[63:32], p[31:0], MULT_LAT, 0);
                end
                default: begin
                    rb = rb >> (i * 3);
                    if (rb == 32'd0) rb = 32'd5;
                    run_op(DIVU, ra, rb, ra % rb, ra / rb, DIV_LAT, 0);
                end
            endcase
        end
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        start = 1'b1; MDUOp = MTHI; A = 32'h1234;
        @(negedge clk);
        check("mthi_hi", HI, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        MDUOp = MTLO; A = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", LO, 32'h5678);
        check("mtlo_hi", HI, 32'h1234);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mt_done", {31'd0, done}, 32'd0);

        start = 1'b1; MDUOp = 3'b110; A = 32'hDEAD_BEEF; B = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("undef_busy", {31'd0, busy}, 32'd0);
        check("undef_hi", HI, 32'h1234);
        check("undef_lo", LO, 32'h5678);

        // MTHI during a MULT must be dropped; the MULT result still lands.
        start = 1'b1; MDUOp = MULT; A = 32'd6; B = 32'd7;
        @(negedge clk);
        MDUOp = MTHI; A = 32'hAAAA_AAAA;
        @(negedge clk);
        start = 1'b0;
        check("mt_busy_hi", HI, 32'h1234);
        repeat (MULT_LAT - 1) @(negedge clk);
        check("mt_busy_done", {31'd0, done}, 32'd1);
        check("mt_busy_res_hi", HI, 32'd0);
        check("mt_busy_res_lo", LO, 32'd42);

        start = 1'b1; MDUOp = MULT; A = 32'd5; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dcount = 0;
        for (int i = 0; i < DIV_LAT + 5; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("arst_no_done", dcount, 0);
        check("arst_idle", {31'd0, busy}, 32'd0);
        check("arst_lo_held", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
